// File: rtl/text_pixel_fetcher_16x4.sv
`default_nettype none
// text_pixel_fetcher_16x4: steps a toggle-driven pixel generator through one text frame
// and presents each captured pixel byte on a valid/ready stream.
module text_pixel_fetcher_16x4 #(
  parameter int TEXT_WIDTH    = 16,
  parameter int TEXT_HEIGHT   = 4,
  parameter int CHAR_HEIGHT   = 16,
  parameter int FETCH_LATENCY = 4,
  localparam int COL_W = (TEXT_WIDTH > 1) ? $clog2(TEXT_WIDTH) : 1,
  localparam int ROW_W = (TEXT_HEIGHT * CHAR_HEIGHT > 1) ? $clog2(TEXT_HEIGHT * CHAR_HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             toggle_restart,
  output logic             toggle_next,
  input  logic [7:0]       gen_pixels,
  input  logic [7:0]       gen_char,
  output logic [7:0]       pix_data,
  output logic [7:0]       pix_char,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             pix_last,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(TEXT_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(TEXT_HEIGHT * CHAR_HEIGHT - 1);
  localparam logic [3:0]       WAIT_LAST = 4'(FETCH_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q;
  logic [3:0]       wait_q;
  logic             restart_q;
  logic             next_q;
  logic [7:0]       data_q;
  logic [7:0]       char_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             last_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [COL_W-1:0] col_d;
  logic [ROW_W-1:0] row_d;
  logic             at_last_pos;

  always_comb begin
    col_d = col_q + COL_W'(1);
    row_d = row_q;
    if (col_q == LAST_COL) begin
      col_d = '0;
      row_d = row_q + ROW_W'(1);
    end
  end

  assign at_last_pos = (col_q == LAST_COL) && (row_q == LAST_ROW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      restart_q <= 1'b0;
      next_q    <= 1'b0;
      data_q    <= '0;
      char_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            restart_q <= ~restart_q;
            col_q     <= '0;
            row_q     <= '0;
            wait_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The generator output has settled by the final count after the toggle edge.
          if (wait_q == WAIT_LAST) begin
            data_q  <= gen_pixels;
            char_q  <= gen_char;
            last_q  <= at_last_pos;
            valid_q <= 1'b1;
            state_q <= S_PRESENT;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        S_PRESENT: begin
          if (valid_q && pix_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              next_q  <= ~next_q;
              col_q   <= col_d;
              row_q   <= row_d;
              wait_q  <= '0;
              state_q <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign toggle_restart = restart_q;
  assign toggle_next    = next_q;
  assign pix_data       = data_q;
  assign pix_char       = char_q;
  assign pix_col        = col_q;
  assign pix_row        = row_q;
  assign pix_last       = last_q;
  assign pix_valid      = valid_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_text_pixel_fetcher_16x4.sv
`default_nettype none
// Bench for text_pixel_fetcher_16x4: behavioural text RAM / font ROM generator with
// 3-cycle latency, directed frame scenarios and per-byte expectations.
module tb_text_pixel_fetcher_16x4;
  localparam int LAT          = 4;
  localparam int NBYTES       = 1024;
  localparam int FRAME_CYCLES = NBYTES * (LAT + 1) + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       pix_ready = 1'b0;
  logic       toggle_restart, toggle_next, pix_last, pix_valid, busy, frame_done;
  logic [7:0] gen_pixels, gen_char, pix_data, pix_char;
  logic [3:0] pix_col;
  logic [5:0] pix_row;

  int tests = 0;
  int fails = 0;

  text_pixel_fetcher_16x4 #(
    .TEXT_WIDTH(16), .TEXT_HEIGHT(4), .CHAR_HEIGHT(16), .FETCH_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .toggle_restart(toggle_restart), .toggle_next(toggle_next),
    .gen_pixels(gen_pixels), .gen_char(gen_char),
    .pix_data(pix_data), .pix_char(pix_char), .pix_col(pix_col), .pix_row(pix_row),
    .pix_last(pix_last), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Generator: text RAM holds char i at address i; font ROM is an arbitrary byte pattern.
  logic [7:0] font_rom [0:1023];
  logic [7:0] text_ram [0:63];

  function automatic logic [7:0] char_of(input int idx);
    return text_ram[(idx / 256) * 16 + idx % 16];
  endfunction

  function automatic logic [7:0] pix_of(input int idx);
    return font_rom[int'(char_of(idx)) * 16 + (idx / 16) % 16];
  endfunction

  int         g_idx = 0;
  int         g_nidx;
  logic       g_prev_rs = 1'b0;
  logic       g_prev_nx = 1'b0;
  logic [7:0] px_pipe [3] = '{default: 8'h00};
  logic [7:0] ch_pipe [3] = '{default: 8'h00};

  assign g_nidx = (toggle_restart !== g_prev_rs) ? 0 :
                  (toggle_next !== g_prev_nx) ? (g_idx + 1) % NBYTES : g_idx;

  always @(posedge clk) begin
    g_idx      <= g_nidx;
    g_prev_rs  <= toggle_restart;
    g_prev_nx  <= toggle_next;
    px_pipe[0] <= pix_of(g_nidx);
    ch_pipe[0] <= char_of(g_nidx);
    px_pipe[1] <= px_pipe[0];
    ch_pipe[1] <= ch_pipe[0];
    px_pipe[2] <= px_pipe[1];
    ch_pipe[2] <= ch_pipe[1];
  end

  assign gen_pixels = px_pipe[2];
  assign gen_char   = ch_pipe[2];

  // Toggle activity monitor.
  logic mon_rs = 1'b0;
  logic mon_nx = 1'b0;
  int   n_rs = 0, n_nx = 0, n_both = 0, n_edge_valid = 0;

  always @(negedge clk) begin
    mon_rs       <= toggle_restart;
    mon_nx       <= toggle_next;
    n_rs         <= n_rs + ((toggle_restart !== mon_rs) ? 1 : 0);
    n_nx         <= n_nx + ((toggle_next !== mon_nx) ? 1 : 0);
    n_both       <= n_both + (((toggle_restart !== mon_rs) && (toggle_next !== mon_nx)) ? 1 : 0);
    n_edge_valid <= n_edge_valid +
                    ((((toggle_restart !== mon_rs) || (toggle_next !== mon_nx)) && pix_valid) ? 1 : 0);
  end

  // mode 0: ready always high; 1: ready low for 10 cycles on byte 5; 2: random ready.
  task automatic run_frame(input int mode, input bit poke, input int abort_at,
                           output int nbytes, output int ncyc, output int ndone);
    int         k, cyc, hold_cnt;
    bit         held, rdy, aborted, finished;
    logic [7:0] hd, hc, exp_char, exp_data;
    logic [3:0] hcol;
    logic [5:0] hrow;
    logic       hlast, hnx;
    k = 0; cyc = 1; hold_cnt = 0; held = 0; aborted = 0; finished = 0;
    ncyc = 0; ndone = 0;
    hd = '0; hc = '0; hcol = '0; hrow = '0; hlast = 0; hnx = 0;
    @(negedge clk);
    start = 1'b1;
    pix_ready = 1'b1;
    for (int t = 0; t < 4 * FRAME_CYCLES && !finished; t++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (abort_at >= 0 && k == abort_at) begin
        reset_n = 1'b0;
        #1;
        tests++;
        if ({toggle_restart, toggle_next, pix_valid, pix_last, busy, frame_done,
             pix_data, pix_char, pix_col, pix_row} !== 34'd0) begin
          fails++;
          $display("FAIL abort_outputs: got %b/%b/%b/%b/%b/%b %h %h %0d %0d, required all 0",
                   toggle_restart, toggle_next, pix_valid, pix_last, busy, frame_done,
                   pix_data, pix_char, pix_col, pix_row);
        end
        aborted = 1;
        finished = 1;
      end else if (frame_done) begin
        ndone++;
        ncyc = cyc;
        if (poke) start = 1'b1;
        finished = 1;
      end else begin
        if (pix_valid && held) begin
          tests++;
          if ({pix_data, pix_char, pix_col, pix_row, pix_last, toggle_next} !==
              {hd, hc, hcol, hrow, hlast, hnx}) begin
            fails++;
            $display("FAIL hold_stable byte %0d: got %h %h %0d %0d %b %b, required %h %h %0d %0d %b %b",
                     k, pix_data, pix_char, pix_col, pix_row, pix_last, toggle_next,
                     hd, hc, hcol, hrow, hlast, hnx);
          end
        end else if (pix_valid) begin
          hd = pix_data; hc = pix_char; hcol = pix_col; hrow = pix_row;
          hlast = pix_last; hnx = toggle_next; held = 1;
        end
        rdy = 1'b1;
        if (mode == 2) rdy = bit'($urandom % 2);
        if (mode == 1 && pix_valid && k == 5 && hold_cnt < 10) begin
          rdy = 1'b0;
          hold_cnt++;
        end
        pix_ready = rdy;
        if (pix_valid && rdy) begin
          exp_char = char_of(k);
          exp_data = pix_of(k);
          tests++;
          if ({pix_col, pix_row, pix_char, pix_data, pix_last} !==
              {4'(k % 16), 6'(k / 16), exp_char, exp_data, (k == NBYTES - 1)}) begin
            fails++;
            $display("FAIL byte %0d: col/row/char/data/last got %0d/%0d/%h/%h/%b, required %0d/%0d/%h/%h/%b",
                     k, pix_col, pix_row, pix_char, pix_data, pix_last,
                     k % 16, k / 16, exp_char, exp_data, (k == NBYTES - 1));
          end
          if (k < 16) begin
            tests++;
            if (pix_char !== 8'(k)) begin
              fails++;
              $display("FAIL first_row_char %0d: got %h, required %h", k, pix_char, 8'(k));
            end
          end
          k++;
          held = 0;
        end
        if (poke && k == 100) start = 1'b1;
      end
    end
    if (!finished) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d bytes without frame_done, required frame_done", k);
    end
    if (aborted) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (frame_done) ndone++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    nbytes = k;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({toggle_restart, toggle_next} !== 2'b00) begin
      fails++; $display("FAIL reset_toggles: got %b%b, required 00", toggle_restart, toggle_next);
    end
    tests++;
    if ({pix_valid, pix_last, busy, frame_done} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b%b%b%b, required 0000", pix_valid, pix_last, busy, frame_done);
    end
    tests++;
    if ({pix_data, pix_char} !== 16'h0000) begin
      fails++; $display("FAIL reset_data: got %h %h, required 00 00", pix_data, pix_char);
    end
    tests++;
    if ({pix_col, pix_row} !== 10'd0) begin
      fails++; $display("FAIL reset_pos: got %0d %0d, required 0 0", pix_col, pix_row);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: busy got %b, required 0", busy);
    end
  endtask

  task automatic check_frame(input string name, input int nb, input int nd,
                             input int rs0, input int nx0);
    #1;
    tests++;
    if (nb !== NBYTES) begin
      fails++; $display("FAIL %s_bytes: got %0d, required %0d", name, nb, NBYTES);
    end
    tests++;
    if (nd !== 1) begin
      fails++; $display("FAIL %s_frame_done: got %0d pulses, required 1", name, nd);
    end
    tests++;
    if (n_rs - rs0 !== 1) begin
      fails++; $display("FAIL %s_restart_edges: got %0d, required 1", name, n_rs - rs0);
    end
    tests++;
    if (n_nx - nx0 !== NBYTES - 1) begin
      fails++; $display("FAIL %s_next_edges: got %0d, required %0d", name, n_nx - nx0, NBYTES - 1);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL %s_busy_end: got %b, required 0", name, busy);
    end
  endtask

  task automatic test_full_frame();
    int nb, nc, nd, rs0, nx0;
    rs0 = n_rs; nx0 = n_nx;
    run_frame(0, 0, -1, nb, nc, nd);
    check_frame("full", nb, nd, rs0, nx0);
    tests++;
    if (nc !== FRAME_CYCLES) begin
      fails++; $display("FAIL frame_cycles: got %0d, required %0d", nc, FRAME_CYCLES);
    end
  endtask

  task automatic test_backpressure();
    int nb, nc, nd, rs0, nx0, ev0;
    rs0 = n_rs; nx0 = n_nx; ev0 = n_edge_valid;
    run_frame(1, 0, -1, nb, nc, nd);
    check_frame("bp", nb, nd, rs0, nx0);
    tests++;
    if (nc !== FRAME_CYCLES + 10) begin
      fails++; $display("FAIL bp_cycles: got %0d, required %0d", nc, FRAME_CYCLES + 10);
    end
    tests++;
    if (n_edge_valid - ev0 !== 0) begin
      fails++; $display("FAIL bp_toggle_while_valid: got %0d, required 0", n_edge_valid - ev0);
    end
  endtask

  task automatic test_start_ignored();
    int nb, nc, nd, rs0, nx0;
    rs0 = n_rs; nx0 = n_nx;
    run_frame(0, 1, -1, nb, nc, nd);
    repeat (3) @(negedge clk);
    check_frame("poke", nb, nd, rs0, nx0);
    tests++;
    if (nc !== FRAME_CYCLES) begin
      fails++; $display("FAIL poke_cycles: got %0d, required %0d", nc, FRAME_CYCLES);
    end
  endtask

  task automatic test_abort();
    int nb, nc, nd, rs0, nx0;
    run_frame(0, 0, 300, nb, nc, nd);
    tests++;
    if (nd !== 0 || nb !== 300) begin
      fails++; $display("FAIL abort_frame: got %0d done / %0d bytes, required 0 / 300", nd, nb);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    rs0 = n_rs; nx0 = n_nx;
    run_frame(0, 0, -1, nb, nc, nd);
    check_frame("after_abort", nb, nd, rs0, nx0);
  endtask

  task automatic test_random_ready();
    int nb, nc, nd, tot_b, tot_d, ev0, both0;
    tot_b = 0; tot_d = 0; ev0 = n_edge_valid; both0 = n_both;
    for (int f = 0; f < 3; f++) begin
      run_frame(2, 0, -1, nb, nc, nd);
      tot_b += nb;
      tot_d += nd;
    end
    #1;
    tests++;
    if (tot_b !== 3 * NBYTES || tot_d !== 3) begin
      fails++; $display("FAIL random_totals: got %0d bytes / %0d done, required %0d / 3", tot_b, tot_d, 3 * NBYTES);
    end
    tests++;
    if (n_edge_valid - ev0 !== 0 || n_both - both0 !== 0) begin
      fails++; $display("FAIL random_toggle_rules: got %0d while valid / %0d simultaneous, required 0 / 0",
                        n_edge_valid - ev0, n_both - both0);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) font_rom[a] = 8'((a * 29 + 7) ^ (a >> 3));
    for (int a = 0; a < 64; a++) text_ram[a] = 8'(a);
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_random_ready();
    tests++;
    if (n_both !== 0) begin
      fails++; $display("FAIL toggles_same_cycle: got %0d, required 0", n_both);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
